// File: rtl/cache_pkg.sv
// Shared constants, FSM encodings and helpers for the direct-mapped write-through data cache.
package cache_pkg;

    localparam int INDEX_W = 6;
    localparam int TAG_W   = 11;
    localparam int LINES   = 2 ** INDEX_W;
    localparam int CNT_W   = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE       = 2'd0;
    localparam state_t READ_MISS  = 2'd1;
    localparam state_t WRITE_THRU = 2'd2;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
        return (en && (value != {CNT_W{1'b1}})) ? value + 1'b1 : value;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous lookup, synchronous fill and update.
module cache_line_array #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int TAG_W   = cache_pkg::TAG_W,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               fill_en,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [DATA_W-1:0]  fill_data,
    input  logic               upd_en,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [DATA_W-1:0]  upd_data
);

    localparam int NUM_LINES = 1 << INDEX_W;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [DATA_W-1:0]    data_mem [NUM_LINES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            assign valid_d[gi] = valid_q[gi] | (fill_en && (fill_index == INDEX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies a line.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fill_data;
        end else if (upd_en) begin
            data_mem[upd_index] <= upd_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
module cache_controller #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int TAG_W   = cache_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    import cache_pkg::*;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [31:0]        line_data;
    logic               hit;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;
    logic               fill_en, upd_en, hit_inc, miss_inc;

    assign index = address[INDEX_W+1:2];
    assign tag   = address[TAG_W+INDEX_W+1:INDEX_W+2];
    assign hit   = line_valid && (line_tag == tag);

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (32)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (index),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_data    (line_data),
        .fill_en    (fill_en),
        .fill_index (index),
        .fill_tag   (tag),
        .fill_data  (sram_read_data),
        .upd_en     (upd_en),
        .upd_index  (index),
        .upd_data   (write_data)
    );

    // Enables are decoded from the current state and the live request so a
    // dropped request releases the SRAM in the same cycle.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b1;
        read_data  = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;

        if (!rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        ready      = 1'b0;
                        sram_wr_en = 1'b1;
                        state_d    = WRITE_THRU;
                    end else if (rd_en) begin
                        if (hit) begin
                            read_data = line_data;
                            hit_inc   = 1'b1;
                        end else begin
                            ready      = 1'b0;
                            sram_rd_en = 1'b1;
                            miss_inc   = 1'b1;
                            state_d    = READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    if (!rd_en) begin
                        state_d = IDLE;
                    end else begin
                        sram_rd_en = 1'b1;
                        if (sram_ready) begin
                            read_data = sram_read_data;
                            fill_en   = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            ready = 1'b0;
                        end
                    end
                end
                WRITE_THRU: begin
                    if (!wr_en) begin
                        state_d = IDLE;
                    end else begin
                        sram_wr_en = 1'b1;
                        if (sram_ready) begin
                            upd_en  = hit;
                            state_d = IDLE;
                        end else begin
                            ready = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hit_count_d  = sat_inc(hit_count_q, hit_inc);
        miss_count_d = sat_inc(miss_count_q, miss_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign sram_address    = address;
    assign sram_write_data = write_data;
    assign hit_count       = hit_count_q;
    assign miss_count      = miss_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed, table-driven bench for cache_controller with a few hand-written multi-cycle sequences.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        sram_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] srdata;
        logic        access;
        logic [31:0] exp_rdata;
        int          exp_hit;
        int          exp_miss;
    } vec_t;

    vec_t vecs[14];

    cache_controller dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .ready           (ready),
        .sram_rd_en      (sram_rd_en),
        .sram_wr_en      (sram_wr_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic [31:0] srdata,
                                input logic access, input logic [31:0] exp_rdata,
                                input int exp_hit, input int exp_miss);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat; v.srdata = srdata;
        v.access = access; v.exp_rdata = exp_rdata; v.exp_hit = exp_hit; v.exp_miss = exp_miss;
        return v;
    endfunction

    task automatic go_idle();
        rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int exp_hit, input int exp_miss);
        check({tag, ".hit_count"}, 32'(hit_count), 32'(exp_hit));
        check({tag, ".miss_count"}, 32'(miss_count), 32'(exp_miss));
    endtask

    // One request; an SRAM access completes after v.lat cycles, a hit in the first cycle.
    task automatic run_txn(input vec_t v, input int id);
        int done;
        done = v.access ? v.lat : 1;
        for (int cyc = 1; cyc <= done; cyc++) begin
            @(posedge clk); #1;
            rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
            sram_read_data = v.srdata;
            sram_ready = v.access && (cyc == done);
            @(negedge clk);
            check($sformatf("t%0d.c%0d.ready", id, cyc), 32'(ready), 32'(cyc == done));
            check($sformatf("t%0d.c%0d.sram_rd_en", id, cyc), 32'(sram_rd_en), 32'(v.access && !v.wr));
            check($sformatf("t%0d.c%0d.sram_wr_en", id, cyc), 32'(sram_wr_en), 32'(v.access && v.wr));
            if (cyc == 1) begin
                check($sformatf("t%0d.sram_address", id), sram_address, v.addr);
                check($sformatf("t%0d.sram_write_data", id), sram_write_data, v.wdata);
            end
            if (cyc == done && v.rd && !v.wr)
                check($sformatf("t%0d.read_data", id), read_data, v.exp_rdata);
        end
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        check($sformatf("t%0d.idle_ready", id), 32'(ready), 32'd1);
        check($sformatf("t%0d.idle_read_data", id), read_data, 32'd0);
        check_counts($sformatf("t%0d", id), v.exp_hit, v.exp_miss);
        $display("txn %0d: rd=%0b wr=%0b addr=%h wdata=%h lat=%0d hits=%0d misses=%0d",
                 id, v.rd, v.wr, v.addr, v.wdata, v.lat, hit_count, miss_count);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 32'h100, 32'h0, 6, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1);
        vecs[1]  = mk(1, 0, 32'h100, 32'h0, 0, 32'h0,        0, 32'hDEADBEEF, 1, 1);
        vecs[2]  = mk(0, 1, 32'h100, 32'h12345678, 3, 32'h0, 1, 32'h0,        1, 1);
        vecs[3]  = mk(1, 0, 32'h100, 32'h0, 0, 32'h0,        0, 32'h12345678, 2, 1);
        vecs[4]  = mk(0, 1, 32'h200, 32'hAAAA5555, 2, 32'h0, 1, 32'h0,        2, 1);
        vecs[5]  = mk(1, 0, 32'h200, 32'h0, 4, 32'hAAAA5555, 1, 32'hAAAA5555, 2, 2);
        vecs[6]  = mk(1, 0, 32'h104, 32'h0, 2, 32'h11111111, 1, 32'h11111111, 2, 3);
        vecs[7]  = mk(1, 0, 32'h504, 32'h0, 3, 32'h22222222, 1, 32'h22222222, 2, 4);
        vecs[8]  = mk(1, 0, 32'h504, 32'h0, 0, 32'h0,        0, 32'h22222222, 3, 4);
        vecs[9]  = mk(1, 0, 32'h104, 32'h0, 2, 32'h33333333, 1, 32'h33333333, 3, 5);
        vecs[10] = mk(1, 0, 32'h104, 32'h0, 0, 32'h0,        0, 32'h33333333, 4, 5);
        vecs[11] = mk(0, 1, 32'h504, 32'h44444444, 2, 32'h0, 1, 32'h0,        4, 5);
        vecs[12] = mk(1, 0, 32'h104, 32'h0, 0, 32'h0,        0, 32'h33333333, 5, 5);
        vecs[13] = mk(1, 0, 32'h107, 32'h0, 0, 32'h0,        0, 32'h33333333, 6, 5);

        // Reset with a read pending: outputs must be quiescent.
        rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; address = 32'h100; write_data = 32'h0;
        sram_read_data = 32'h0; sram_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.sram_rd_en", 32'(sram_rd_en), 32'd0);
        check("rst.sram_wr_en", 32'(sram_wr_en), 32'd0);
        check("rst.read_data", read_data, 32'd0);
        check_counts("rst", 0, 0);
        @(posedge clk); #1;
        rst = 1'b1; go_idle();

        for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

        // Write dropped while waiting on the SRAM: enables release, line untouched.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'h104; write_data = 32'h55555555;
        @(negedge clk);
        check("drop.c1.sram_wr_en", 32'(sram_wr_en), 32'd1);
        check("drop.c1.ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("drop.c2.sram_wr_en", 32'(sram_wr_en), 32'd0);
        check("drop.c2.ready", 32'(ready), 32'd1);
        $display("txn drop: wr 0x104 abandoned in WRITE_THRU");
        run_txn(mk(1, 0, 32'h104, 32'h0, 0, 32'h0, 0, 32'h33333333, 7, 5), 14);

        // Miss completion followed back-to-back by a hit on the freshly filled line.
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'h400; sram_read_data = 32'h0BADF00D; sram_ready = 1'b0;
        @(negedge clk);
        check("b2b.c1.sram_rd_en", 32'(sram_rd_en), 32'd1);
        check("b2b.c1.ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        check("b2b.c2.ready", 32'(ready), 32'd1);
        check("b2b.c2.read_data", read_data, 32'h0BADF00D);
        @(posedge clk); #1;
        sram_ready = 1'b0; sram_read_data = 32'h0;
        @(negedge clk);
        check("b2b.c3.ready", 32'(ready), 32'd1);
        check("b2b.c3.sram_rd_en", 32'(sram_rd_en), 32'd0);
        check("b2b.c3.read_data", read_data, 32'h0BADF00D);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        check_counts("b2b", 8, 6);
        $display("txn b2b: miss 0x400 then same-address hit next cycle");

        // Reset in the middle of a read miss, with a late sram_ready that must not fill.
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'h300; sram_read_data = 32'h77777777;
        @(posedge clk); #1;
        @(negedge clk);
        check("rmid.c2.sram_rd_en", 32'(sram_rd_en), 32'd1);
        check("rmid.c2.ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; sram_ready = 1'b1;
        @(negedge clk);
        check("rmid.c3.sram_rd_en", 32'(sram_rd_en), 32'd0);
        check("rmid.c3.ready", 32'(ready), 32'd1);
        check("rmid.c3.read_data", read_data, 32'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        @(negedge clk);
        check_counts("rmid", 0, 0);
        @(posedge clk); #1;
        rst = 1'b1; go_idle();
        $display("txn rmid: reset during READ_MISS of 0x300");
        run_txn(mk(1, 0, 32'h300, 32'h0, 2, 32'h99999999, 1, 32'h99999999, 0, 1), 15);
        run_txn(mk(1, 0, 32'h104, 32'h0, 3, 32'h33333333, 1, 32'h33333333, 0, 2), 16);
        run_txn(mk(1, 0, 32'h300, 32'h0, 0, 32'h0, 0, 32'h99999999, 1, 2), 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
